// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// The master side is the sequencer/writeback pair; the slave side is the ALU.
interface alu_pipe_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] a_in;
    logic [DATA_WIDTH-1:0] b_in;
    logic [ADDR_WIDTH-1:0] opcode;
    logic                  use_acc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  carry_out;
    logic                  zero_out;
    logic                  neg_out;
    logic                  ovf_out;
    logic [DATA_WIDTH-1:0] acc_out;

    modport master (
        output in_valid, a_in, b_in, opcode, use_acc, out_ready,
        input  in_ready, out_valid, data_out, carry_out, zero_out, neg_out, ovf_out, acc_out
    );

    modport slave (
        input  in_valid, a_in, b_in, opcode, use_acc, out_ready,
        output in_ready, out_valid, data_out, carry_out, zero_out, neg_out, ovf_out, acc_out
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with accumulator and status flags.
// S1 holds operands, compute sits between S1 and S2, S2 holds result and flags.
module alu_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    alu_pipe_if.slave bus
);
    localparam int unsigned W = DATA_WIDTH;

    logic                  rdy_q;
    logic                  s1_valid_q;
    logic [W-1:0]          s1_a_q;
    logic [W-1:0]          s1_b_q;
    logic [ADDR_WIDTH-1:0] s1_op_q;
    logic                  s1_use_acc_q;

    logic                  out_valid_q;
    logic [W-1:0]          data_q;
    logic                  carry_q;
    logic                  zero_q;
    logic                  neg_q;
    logic                  ovf_q;
    logic [W-1:0]          acc_q;

    logic                  s2_adv;
    logic                  op_undef;
    logic [3:0]            op_lo;
    logic [W-1:0]          opa;
    logic [W:0]            ea;
    logic [W:0]            eb;
    logic [W:0]            one;
    logic [W:0]            res;
    logic                  ovf_c;
    logic                  sa;
    logic                  sb;
    logic                  sr;

    // rdy_q keeps in_ready low during reset and for the first edge after it
    assign s2_adv       = !out_valid_q | bus.out_ready;
    assign bus.in_ready = rdy_q & (!s1_valid_q | s2_adv);

    if (ADDR_WIDTH > 4) begin : g_wide_op
        assign op_undef = |s1_op_q[ADDR_WIDTH-1:4];
    end else begin : g_narrow_op
        assign op_undef = 1'b0;
    end

    assign op_lo = s1_op_q[3:0];
    assign opa   = s1_use_acc_q ? acc_q : s1_a_q;
    assign ea    = {1'b0, opa};
    assign eb    = {1'b0, s1_b_q};
    assign one   = {{W{1'b0}}, 1'b1};

    always_comb begin
        res   = '0;
        ovf_c = 1'b0;
        sa    = opa[W-1];
        sb    = s1_b_q[W-1];
        case (op_lo)
            4'd0:    res = ea;
            4'd1:    res = ea + eb;
            4'd2:    res = ea + eb + one;
            4'd3:    res = ea - eb;
            4'd4:    res = ea - eb - one;
            4'd5:    res = ea + one;
            4'd6:    res = ea - one;
            4'd7:    res = eb;
            4'd8:    res = ea | eb;
            4'd9:    res = ea ^ eb;
            4'd10:   res = ea & eb;
            4'd11:   res = {1'b0, ~opa};
            4'd12:   res = {opa, 1'b0};
            4'd13:   res = {opa[0], 1'b0, opa[W-1:1]};
            4'd14:   res = {opa[0], opa[W-1], opa[W-1:1]};
            4'd15:   res = '0;
            default: res = '0;
        endcase
        sr = res[W-1];
        case (op_lo)
            4'd1, 4'd2: ovf_c = (sa == sb) && (sr != sa);
            4'd5:       ovf_c = !sa && (sr != sa);
            4'd3, 4'd4: ovf_c = (sa != sb) && (sr != sa);
            4'd6:       ovf_c = sa && (sr != sa);
            default:    ovf_c = 1'b0;
        endcase
        if (op_undef) begin
            res   = '0;
            ovf_c = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= '0;
            s1_use_acc_q <= 1'b0;
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            carry_q      <= 1'b0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            acc_q        <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    data_q  <= res[W-1:0];
                    carry_q <= res[W];
                    zero_q  <= (res[W-1:0] == '0);
                    neg_q   <= res[W-1];
                    ovf_q   <= ovf_c;
                    acc_q   <= res[W-1:0];
                end
            end
            // S1 is either empty or draining into S2 whenever in_ready is high
            if (bus.in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a_q       <= bus.a_in;
                    s1_b_q       <= bus.b_in;
                    s1_op_q      <= bus.opcode;
                    s1_use_acc_q <= bus.use_acc;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.carry_out = carry_q;
    assign bus.zero_out  = zero_q;
    assign bus.neg_out   = neg_q;
    assign bus.ovf_out   = ovf_q;
    assign bus.acc_out   = acc_q;
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's combinational ALU. It keeps the same 12 base opcodes and adds shifts, a result accumulator and a status-flag set (carry, zero, negative, overflow). Operands enter through a valid/ready handshake, pass through two register stages, and leave through a valid/ready handshake with full backpressure. The block sits between the datapath sequencer and the writeback buffer.

Parameters:
DATA_WIDTH, 8, operand/result width; legal values are 4 or more.
ADDR_WIDTH, 4, opcode width; legal values are 4 or more. Opcode values of 16 or above are undefined operations.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately; deassertion is synchronous to clk externally.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat this cycle.
a_in  input  DATA_WIDTH  operand A.
b_in  input  DATA_WIDTH  operand B.
opcode  input  ADDR_WIDTH  operation select.
use_acc  input  1  when 1, the accumulator replaces operand A.
out_valid  output  1  result beat valid.
out_ready  input  1  downstream accepts the result.
data_out  output  DATA_WIDTH  result.
carry_out  output  1  carry/borrow/shifted-out bit.
zero_out  output  1  result equals 0.
neg_out  output  1  result MSB.
ovf_out  output  1  signed overflow.
acc_out  output  DATA_WIDTH  current accumulator value.

Behaviour:
- Reset (rst=0): in_ready=0, out_valid=0, data_out=0, all flags=0, acc=0, s1_valid=0. After reset is released, in_ready rises to 1 on the first clk edge.
- Pipeline structure:
  - S1 registers {a, b, opcode, use_acc}.
  - Compute logic sits between S1 and S2.
  - S2 registers {data_out, carry_out, zero_out, neg_out, ovf_out}.
- Advance rules:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = s2_adv.
  - in_ready = !s1_valid | s2_adv.
  - A beat is accepted when in_valid & in_ready.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+1 when there is no stall. Throughput is one beat per cycle.
- Backpressure: while out_ready=0 and out_valid=1, S2 holds and S1 holds if full. At most 2 beats are in flight. No loss, no duplication, order preserved.
- Simultaneous output handshake and input accept in the same cycle is legal and sustains full throughput.
- Operand A at compute time = use_acc ? acc : S1.a.
- The accumulator loads the computed result on every S2 load, so back-to-back use_acc ops see the previous result with no bubble.
- Arithmetic uses a DATA_WIDTH+1 bit result; carry_out is the top bit (two's-complement wrap for subtracts, so a borrow gives carry=1).
- Opcodes:
  - 0 A.
  - 1 A+B.
  - 2 A+B+1.
  - 3 A-B.
  - 4 A-B-1.
  - 5 A+1.
  - 6 A-1.
  - 7 B.
  - 8 OR.
  - 9 XOR.
  - 10 AND.
  - 11 ~A.
  - 12 A<<1, carry = A[MSB].
  - 13 logical A>>1, carry = A[0].
  - 14 arithmetic A>>1, carry = A[0].
  - 15 clear: result 0, carry 0.
  - Opcodes 0, 7 and 8-11 give carry 0.
  - Undefined opcodes give result 0 and all flags 0 except zero=1.
- Overflow:
  - Add ops (1, 2, 5): sign(A)==sign(B') and sign(R)!=sign(A), where B' is B or 0 as applicable.
  - Sub ops (3, 4, 6): sign(A)!=sign(B') and sign(R)!=sign(A).
  - All other ops: 0.
- zero_out and neg_out are derived from the DATA_WIDTH-bit result only.
- Outputs are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all in-flight beats and zeroes acc.

Test Plan:
- Add with carry: a=0xFF, b=0x01, opcode 1, accepted at cycle 0 → out_valid at cycle 2, data 0x00, carry 1, zero 1, neg 0, ovf 0.
- Signed subtract overflow: a=0x80, b=0x01, opcode 3 → data 0x7F, carry 0, ovf 1, neg 0. Then a=0x01, b=0x02, opcode 3 → data 0xFF, carry 1, neg 1.
- Accumulator chain: back-to-back beats with no bubble:
  - {op 1, a=5, b=3, use_acc=0} → 0x08.
  - {op 1, b=2, use_acc=1} → 0x0A.
  - {op 12, use_acc=1} → 0x14, carry 0.
  - acc_out ends at 0x14.
- Backpressure: out_ready=0, five beats offered → exactly 2 accepted, in_ready=0 from then on. Release out_ready → all five results emerge in order with no gaps.
- Shifts and undefined opcodes:
  - a=0x81, op 12 → 0x02, carry 1.
  - a=0x81, op 14 → 0xC0, carry 1.
  - With ADDR_WIDTH=5, op 16 → 0x00, zero 1.
- Reset mid-stream: drop rst while out_valid=1 and S1 is full → out_valid, in_ready, acc_out are 0 immediately. After release, the first new beat yields a correct result with no stale data.
